// File: rtl/quad_pkg.sv
// Shared constants and Gray-code transition decode for the quadrature decoder.
package quad_pkg;

    localparam logic [1:0] ST_00 = 2'b00;
    localparam logic [1:0] ST_01 = 2'b01;
    localparam logic [1:0] ST_11 = 2'b11;
    localparam logic [1:0] ST_10 = 2'b10;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef struct packed {
        logic valid;
        logic dir;
        logic illegal;
    } dec_t;

    function automatic logic [1:0] gray_up(input logic [1:0] p);
        case (p)
            ST_00:   return ST_01;
            ST_01:   return ST_11;
            ST_11:   return ST_10;
            default: return ST_00;
        endcase
    endfunction

    function automatic logic [1:0] gray_down(input logic [1:0] p);
        case (p)
            ST_00:   return ST_10;
            ST_10:   return ST_11;
            ST_11:   return ST_01;
            default: return ST_00;
        endcase
    endfunction

    // Map previous/current phase state to a step, a direction or an illegal jump.
    function automatic dec_t quad_decode(input logic [1:0] p, input logic [1:0] s);
        dec_t d;
        d = '0;
        if (s == (p ^ 2'b11)) begin
            d.illegal = 1'b1;
        end else if (s == gray_up(p)) begin
            d.valid = 1'b1;
            d.dir   = DIR_UP;
        end else if (s == gray_down(p)) begin
            d.valid = 1'b1;
            d.dir   = DIR_DOWN;
        end
        return d;
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder phases, control and position outputs of the quadrature decoder.
interface quad_decoder_if #(parameter int unsigned WIDTH = 8);
    logic             a_in;
    logic             b_in;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             clr_err;
    logic [WIDTH-1:0] out;
    logic             up_down;
    logic             step;
    logic             err;

    modport master (
        output a_in, b_in, enable, load, data, clr_err,
        input  out, up_down, step, err
    );

    modport slave (
        input  a_in, b_in, enable, load, data, clr_err,
        output out, up_down, step, err
    );
endinterface

// File: rtl/quad_filter.sv
// Two-flop synchroniser plus stability counter for one encoder phase.
module quad_filter #(
    parameter int unsigned FILTER = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic valid
);
    localparam int unsigned CW = (FILTER > 1) ? $clog2(FILTER) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic [1:0]    fill;

    // valid marks the first time level reflects a real sampled input after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            fill  <= '0;
            level <= 1'b0;
            valid <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (fill != 2'd2) fill <= fill + 2'd1;
            if (sync2 != level) begin
                if (cnt == CW'(FILTER - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                    valid <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
                if (fill == 2'd2) valid <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/quad_decoder.sv
// Quadrature position decoder: filtered A/B phases drive a loadable wrapping position.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned FILTER = 3
) (
    input logic            clk,
    input logic            reset,
    quad_decoder_if.slave  bus
);
    logic             a_f, b_f, a_v, b_v;
    logic [1:0]       s, p, p_n;
    logic             primed, primed_n;
    logic [WIDTH-1:0] out_q, out_n;
    logic             up_down_q, up_down_n;
    logic             step_q, step_n;
    logic             err_q, err_n;
    dec_t             dec;

    quad_filter #(.FILTER(FILTER)) u_filt_a (
        .clk(clk), .reset(reset), .raw(bus.a_in), .level(a_f), .valid(a_v)
    );
    quad_filter #(.FILTER(FILTER)) u_filt_b (
        .clk(clk), .reset(reset), .raw(bus.b_in), .level(b_f), .valid(b_v)
    );

    assign s = {a_f, b_f};

    always_comb begin
        dec       = quad_decode(p, s);
        p_n       = p;
        primed_n  = primed;
        out_n     = out_q;
        up_down_n = up_down_q;
        step_n    = 1'b0;
        err_n     = err_q;
        if (bus.clr_err) err_n = 1'b0;
        if (!primed) begin
            // first real filtered state is adopted silently
            if (a_v && b_v) begin
                p_n      = s;
                primed_n = 1'b1;
            end
        end else if (s != p) begin
            p_n = s;
            if (dec.illegal) begin
                err_n = 1'b1;
            end else if (dec.valid) begin
                up_down_n = dec.dir;
                if (bus.enable) begin
                    out_n  = (dec.dir == DIR_UP) ? out_q + WIDTH'(1) : out_q - WIDTH'(1);
                    step_n = 1'b1;
                end
            end
        end
        if (bus.load) begin
            out_n  = bus.data;
            step_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p         <= ST_00;
            primed    <= 1'b0;
            out_q     <= '0;
            up_down_q <= DIR_UP;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            p         <= p_n;
            primed    <= primed_n;
            out_q     <= out_n;
            up_down_q <= up_down_n;
            step_q    <= step_n;
            err_q     <= err_n;
        end
    end

    assign bus.out     = out_q;
    assign bus.up_down = up_down_q;
    assign bus.step    = step_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: step strobes are checked against a scoreboard queue.
module tb_quad_decoder;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned FILTER = 3;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic             dir;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    exp_t sb[$];
    int   step_cyc[$];

    quad_decoder_if #(.WIDTH(WIDTH)) bus ();

    quad_decoder #(.WIDTH(WIDTH), .FILTER(FILTER)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every step strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.step === 1'b1) begin
            step_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_step: got step with out=%0h expected no step", bus.out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("step_out", 32'(bus.out), 32'(e.out));
                check("step_dir", 32'(bus.up_down), 32'(e.dir));
            end
        end
    end

    task automatic drive(input logic [1:0] ab, input int n);
        bus.a_in = ab[1];
        bus.b_in = ab[0];
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_step(input logic [WIDTH-1:0] o, input logic d);
        exp_t e;
        e.out = o;
        e.dir = d;
        sb.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        bus.a_in = 1'b0; bus.b_in = 1'b0;
        bus.enable = 1'b1; bus.load = 1'b0; bus.data = '0; bus.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out", 32'(bus.out), 32'h0);
        check("rst_dir", 32'(bus.up_down), 32'h1);
        check("rst_step", 32'(bus.step), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        // up count, levels held 6 cycles
        step_cyc.delete();
        expect_step(8'h01, 1'b1); expect_step(8'h02, 1'b1);
        expect_step(8'h03, 1'b1); expect_step(8'h04, 1'b1);
        drive(2'b01, 6); drive(2'b11, 6); drive(2'b10, 6); drive(2'b00, 6);
        @(negedge clk);
        check("up_out", 32'(bus.out), 32'h04);
        check("up_dir", 32'(bus.up_down), 32'h1);
        check("up_nsteps", 32'(step_cyc.size()), 32'd4);
        if (step_cyc.size() >= 4)
            for (int i = 1; i < 4; i++)
                check("up_gap", 32'(step_cyc[i] - step_cyc[i-1]), 32'd6);

        // load then down with wrap
        bus.load = 1'b1; bus.data = 8'h01;
        @(negedge clk);
        bus.load = 1'b0;
        check("load_out", 32'(bus.out), 32'h01);
        expect_step(8'h00, 1'b0); expect_step(8'hFF, 1'b0); expect_step(8'hFE, 1'b0);
        drive(2'b10, 6); drive(2'b11, 6); drive(2'b01, 6);
        check("down_out", 32'(bus.out), 32'hFE);
        check("down_dir", 32'(bus.up_down), 32'h0);
        check("down_err", 32'(bus.err), 32'h0);
        expect_step(8'hFD, 1'b0);
        drive(2'b00, 6);

        // glitch rejection
        drive(2'b10, 2); drive(2'b00, 10);
        check("glitch_out", 32'(bus.out), 32'hFD);
        check("glitch_err", 32'(bus.err), 32'h0);

        // illegal transition, clear, and set-wins-over-clear
        drive(2'b11, 8);
        check("illegal_err", 32'(bus.err), 32'h1);
        check("illegal_out", 32'(bus.out), 32'hFD);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        check("clr_err", 32'(bus.err), 32'h0);
        drive(2'b00, 5);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        check("set_wins", 32'(bus.err), 32'h1);
        check("set_wins_out", 32'(bus.out), 32'hFD);
        repeat (3) @(negedge clk);

        // enable=0 steps then load colliding with a step
        bus.enable = 1'b0;
        drive(2'b01, 6); drive(2'b11, 6);
        check("hold_out", 32'(bus.out), 32'hFD);
        check("hold_dir", 32'(bus.up_down), 32'h1);
        bus.enable = 1'b1;
        drive(2'b10, 5);
        bus.load = 1'b1; bus.data = 8'h0F;
        @(negedge clk);
        bus.load = 1'b0;
        check("ldcol_out", 32'(bus.out), 32'h0F);
        check("ldcol_step", 32'(bus.step), 32'h0);
        repeat (3) @(negedge clk);

        // reset during a filter count at 11
        drive(2'b11, 3);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst_out", 32'(bus.out), 32'h0);
        check("mrst_err", 32'(bus.err), 32'h0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("prime_err", 32'(bus.err), 32'h0);
        check("prime_out", 32'(bus.out), 32'h0);
        expect_step(8'h01, 1'b1);
        drive(2'b10, 8);
        check("after_rst_out", 32'(bus.out), 32'h01);

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature (A/B) position decoder: synchronises and glitch-filters two asynchronous encoder phases, then decodes Gray-code transitions into a direction and a single-cycle step strobe.
- Keeps a loadable, wrapping position register.
- Acts as the receiving end of an incremental encoder link. It produces the same up/down, enable-style stepping and load semantics as the team's up/down counter, so downstream logic sees an identical position interface.

Parameters:
- WIDTH, 8: position register width; wraps modulo 2^WIDTH.
- FILTER, 3: consecutive identical synchronised samples (>=1) required before a phase level is accepted.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- a_in  input  1  encoder phase A, asynchronous
- b_in  input  1  encoder phase B, asynchronous
- enable  input  1  1 = decoded steps update out; 0 = steps tracked but not counted
- load  input  1  synchronous load of data into out
- data  input  WIDTH  load value
- clr_err  input  1  clears err
- out  output  WIDTH  current position
- up_down  output  1  direction of last accepted step: 1 = up, 0 = down
- step  output  1  one-cycle strobe when out changed by a decoded step
- err  output  1  sticky illegal-transition flag

Behaviour:
- Reset: this is the already-decided clock/reset scheme. There is one clock, clk. reset is synchronous and active-high.
  - While reset is high at a rising edge: out=0, up_down=1, step=0, err=0.
  - Sync flops, filter counters and filtered state are cleared.
  - primed is cleared.
  - Reset asserted mid-step discards any partially filtered transition.
- Synchronisation: a_in and b_in each pass through a 2-flop synchroniser.
- Filter, per phase:
  - The counter increments while the synchronised value differs from the filtered value, and clears when they match.
  - When the count reaches FILTER, the filtered value takes the synchronised value and the counter clears.
  - Pulses shorter than FILTER cycles are ignored.
- Decode: filtered state S = {A,B} is compared each cycle with the previous registered state P.
  - Up sequence: 00->01->11->10->00.
  - Down sequence: reverse of the up sequence.
  - Both bits changed: illegal. Set err; no step; P <- S.
  - S == P: nothing.
- Priming: the first filtered state after reset is adopted into P with no step and no err. This sets primed=1.
- Counting, when a legal step is decoded:
  - up_down <- direction, regardless of enable.
  - If enable=1: out <- out +/- 1 (wraps 0xFF->0x00 up and 0x00->0xFF down at WIDTH=8), and step=1 for exactly one cycle.
  - If enable=0: out holds, step=0, P still updates.
- Latency: out and step update on the (FILTER+3)th rising edge. Edge 1 is the first edge that samples the new a_in/b_in level.
- Priority per cycle: reset > load > step.
  - load: out <- data, step=0.
  - A step decoded in the same cycle as load is consumed and lost; up_down still updates.
- err:
  - Set by an illegal transition.
  - Cleared by clr_err.
  - Simultaneous set and clear: set wins.
  - err does not block counting.

Decomposition:
- Shared package quad_pkg:
  - Localparams for the four Gray states (ST_00, ST_01, ST_11, ST_10).
  - DIR_UP=1 and DIR_DOWN=0.
  - A decode function mapping {P,S} to {valid, dir, illegal}.
- One sub-module, quad_filter: 2-flop synchroniser plus FILTER-deep stability counter for one phase. It is instantiated twice (A and B).
- Decode, priming and the position register are in quad_decoder.

Test Plan (WIDTH=8, FILTER=3):
- Up count: reset, enable=1, apply up sequence (00,01,11,10,00), each level held 6 cycles -> out steps 1,2,3,4; up_down=1; step pulses once per level; each pulse 6 cycles after the previous one.
- Down and wrap: load data=0x01, then down sequence of 3 steps -> out 0x00, 0xFF, 0xFE; up_down=0; err=0.
- Glitch rejection: from 00, drive a_in=1 for 2 cycles then back to 0 -> out, step and err unchanged.
- Illegal transition: from 00, drive a_in and b_in to 1 together -> err=1, out unchanged. Then clr_err=1 for 1 cycle -> err=0. A new illegal transition in the same cycle as clr_err -> err stays 1.
- enable/load interaction: enable=0 during 2 up steps -> out held, up_down=1. Load 0x0F in the same cycle a step is decoded -> out=0x0F, step=0.
- Reset mid-operation: assert reset during a filter count with inputs at 11 -> out=0. After release, no step and no err on priming. The next legal up step (11->10) -> out=1.
